mem_word_arbiter: RTL and testbench



---
 rtl/mem_word_arbiter_pkg.sv | 17 +
 rtl/mem_word_arbiter_rr_picker.sv | 25 ++
 rtl/mem_word_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_word_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_word_arbiter_pkg.sv
// rtl/mem_word_arbiter_pkg.sv - shared constants and FSM encoding for the word arbiter
package mem_word_arbiter_pkg;

   localparam int MEM_DEPTH  = 1024;
   localparam int MEM_WIDTH  = 8;
   localparam int WORD_WIDTH = 16;
   localparam int REQ_AW     = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      CAP  = 3'd3,
      DONE = 3'd4
   } arb_state_t;

endpackage

// File: rtl/mem_word_arbiter_rr_picker.sv
// rtl/mem_word_arbiter_rr_picker.sv - combinational round-robin one-hot picker
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] winner,
   output logic            valid
);

   // scan from the index after the last grantee, wrapping, first requester wins
   always_comb begin
      winner = '0;
      valid  = |req;
      for (int k = 1; k <= NREQ; k++) begin
         int cand;
         cand = (int'(last) + k) % NREQ;
         if (winner == '0 && req[cand]) begin
            winner[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_word_arbiter.sv
// rtl/mem_word_arbiter.sv - round-robin word-to-byte arbiter for the shared local memory
module mem_word_arbiter #(
   parameter int NREQ       = 4,
   parameter int WORD_WIDTH = mem_word_arbiter_pkg::WORD_WIDTH,
   parameter int MEM_WIDTH  = mem_word_arbiter_pkg::MEM_WIDTH,
   parameter int MEM_AW     = 10
) (
   input  logic                                         clock,
   input  logic                                         nrst,
   input  logic [NREQ-1:0]                              req,
   input  logic [NREQ-1:0]                              wr,
   input  logic [NREQ*mem_word_arbiter_pkg::REQ_AW-1:0] addr,
   input  logic [NREQ*WORD_WIDTH-1:0]                   wdata,
   output logic [NREQ-1:0]                              grant,
   output logic [NREQ-1:0]                              ack,
   output logic [WORD_WIDTH-1:0]                        rdata,
   output logic                                         busy,
   output logic [MEM_AW-1:0]                            mem_addr,
   output logic                                         mem_wr_en,
   output logic [MEM_WIDTH-1:0]                         mem_din,
   input  logic [MEM_WIDTH-1:0]                         mem_dout
);

   import mem_word_arbiter_pkg::*;

   localparam int IW = $clog2(NREQ);

   arb_state_t             state;
   arb_state_t             state_nx;
   logic [NREQ-1:0]        win_oh;
   logic                   win_valid;
   logic [IW-1:0]          win_idx;
   logic [NREQ-1:0]        owner_q;
   logic [IW-1:0]          owner_idx_q;
   logic [IW-1:0]          last_q;
   logic                   wr_q;
   logic [MEM_AW-1:0]      addr_q;
   logic [WORD_WIDTH-1:0]  wdata_q;
   logic [MEM_WIDTH-1:0]   lo_q;
   logic                   unused_addr_hi;

   rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .req    (req),
      .last   (last_q),
      .winner (win_oh),
      .valid  (win_valid)
   );

   // one-hot winner to index, used to select the winner's request fields
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_idx = IW'(i);
         end
      end
   end

   // requester address bits above the memory range are deliberately dropped
   always_comb begin
      unused_addr_hi = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         unused_addr_hi = unused_addr_hi ^ (^addr[i*REQ_AW+MEM_AW +: REQ_AW-MEM_AW]);
      end
   end

   // state register; reset aborts any transaction in flight
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next state and all port-facing outputs, decoded from the current state
   always_comb begin
      state_nx  = state;
      grant     = '0;
      ack       = '0;
      busy      = 1'b0;
      mem_addr  = '0;
      mem_wr_en = 1'b0;
      mem_din   = '0;
      case (state)
         IDLE: begin
            if (win_valid) begin
               state_nx = LO;
            end
         end
         LO: begin
            grant     = owner_q;
            busy      = 1'b1;
            mem_addr  = addr_q;
            mem_wr_en = wr_q;
            mem_din   = wdata_q[MEM_WIDTH-1:0];
            state_nx  = HI;
         end
         HI: begin
            grant     = owner_q;
            busy      = 1'b1;
            mem_addr  = addr_q + MEM_AW'(1);
            mem_wr_en = wr_q;
            mem_din   = wdata_q[WORD_WIDTH-1:MEM_WIDTH];
            state_nx  = wr_q ? DONE : CAP;
         end
         CAP: begin
            grant    = owner_q;
            busy     = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            grant    = owner_q;
            busy     = 1'b1;
            ack      = owner_q;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // latch the winner's request, assemble read bytes, advance the fairness pointer
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         owner_q     <= '0;
         owner_idx_q <= '0;
         last_q      <= IW'(NREQ - 1);
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lo_q        <= '0;
         rdata       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  owner_q     <= win_oh;
                  owner_idx_q <= win_idx;
                  wr_q        <= wr[win_idx];
                  addr_q      <= addr[int'(win_idx)*REQ_AW +: MEM_AW];
                  wdata_q     <= wdata[int'(win_idx)*WORD_WIDTH +: WORD_WIDTH];
               end
            end
            HI: begin
               if (!wr_q) begin
                  lo_q <= mem_dout;
               end
            end
            CAP: begin
               rdata <= {mem_dout, lo_q};
            end
            DONE: begin
               last_q <= owner_idx_q;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_word_arbiter.sv
// tb/tb_mem_word_arbiter.sv - self-checking bench for mem_word_arbiter
module tb_mem_word_arbiter;

   logic        clock;
   logic        nrst;
   logic [3:0]  req_v;
   logic [3:0]  wr_v;
   logic [63:0] addr_v;
   logic [63:0] wdata_v;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic [15:0] rdata;
   logic        busy;
   logic [9:0]  mem_addr;
   logic        mem_wr_en;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;

   mem_word_arbiter #(
      .NREQ       (4),
      .WORD_WIDTH (16),
      .MEM_WIDTH  (8),
      .MEM_AW     (10)
   ) dut (
      .clock     (clock),
      .nrst      (nrst),
      .req       (req_v),
      .wr        (wr_v),
      .addr      (addr_v),
      .wdata     (wdata_v),
      .grant     (grant),
      .ack       (ack),
      .rdata     (rdata),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_wr_en (mem_wr_en),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int wr_pulses = 0;
   int exp_pulses = 0;
   int m_last = 3;

   logic [7:0]  mem [1024];
   logic [7:0]  ref_mem [1024];
   logic        t_wr [4];
   logic [15:0] t_addr [4];
   logic [15:0] t_wdata [4];

   typedef struct {
      int          idx;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t tbl [8];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // memory macro: one-cycle read latency, write on strobe
   always @(posedge clock) begin
      if (mem_wr_en) begin
         mem[mem_addr] <= mem_din;
         wr_pulses++;
      end
      mem_dout <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // structural invariants sampled mid-cycle
   always @(negedge clock) begin
      if (nrst) begin
         chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
         chk("ack_outside_grant", 32'(ack & ~grant), 32'd0);
         chk("wr_en_while_idle", 32'(mem_wr_en & ~busy), 32'd0);
      end
   end

   function automatic int model_pick(input logic [3:0] p, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (p[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [15:0] ref_word(input logic [15:0] a);
      int lo;
      lo = int'(a[9:0]);
      return {ref_mem[(lo + 1) % 1024], ref_mem[lo]};
   endfunction

   task automatic drive_fields();
      for (int i = 0; i < 4; i++) begin
         wr_v[i]          = t_wr[i];
         addr_v[i*16+:16]  = t_addr[i];
         wdata_v[i*16+:16] = t_wdata[i];
      end
   endtask

   task automatic do_reset();
      nrst  = 1'b0;
      req_v = '0;
      @(posedge clock);
      #1;
      nrst   = 1'b1;
      m_last = 3;
   endtask

   // called #1 after an edge with the DUT idle; serves every requester in mask
   task automatic run_round(input logic [3:0] mask);
      logic [3:0] pend;
      int         w;
      int         lat;
      int         exp_lat;
      bit         first;
      logic [15:0] a;
      pend  = mask;
      first = 1'b1;
      drive_fields();
      req_v = mask;
      while (pend != 0) begin
         w       = model_pick(pend, m_last);
         exp_lat = (t_wr[w] ? 3 : 4) + (first ? 0 : 1);
         lat     = 0;
         do begin
            @(posedge clock);
            #1;
            lat++;
         end while (ack == 0 && lat < 12);
         chk("ack_vector", 32'(ack), 32'(1) << w);
         chk("ack_latency", 32'(lat), 32'(exp_lat));
         a = t_addr[w];
         if (t_wr[w]) begin
            ref_mem[int'(a[9:0])]           = t_wdata[w][7:0];
            ref_mem[(int'(a[9:0]) + 1) % 1024] = t_wdata[w][15:8];
            exp_pulses += 2;
         end else begin
            chk("read_word", 32'(rdata), 32'(ref_word(a)));
         end
         req_v[w] = 1'b0;
         pend[w]  = 1'b0;
         m_last   = w;
         first    = 1'b0;
         if (ack == 0) begin
            req_v = '0;
            pend  = '0;
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [15:0] r;
      nrst    = 1'b0;
      req_v   = '0;
      wr_v    = '0;
      addr_v  = '0;
      wdata_v = '0;
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      for (int i = 0; i < 4; i++) begin
         t_wr[i]    = 1'b0;
         t_addr[i]  = '0;
         t_wdata[i] = '0;
      end

      tbl[0] = '{1, 1'b0, 16'h0002, 16'h0000, 16'hABCD};
      tbl[1] = '{2, 1'b1, 16'h03FF, 16'h1234, 16'hABCD};
      tbl[2] = '{3, 1'b0, 16'h03FF, 16'h0000, 16'h1234};
      tbl[3] = '{0, 1'b0, 16'h0000, 16'h0000, 16'h0012};
      tbl[4] = '{1, 1'b1, 16'h07FE, 16'hBEEF, 16'h0012};
      tbl[5] = '{2, 1'b0, 16'h03FE, 16'h0000, 16'hBEEF};
      tbl[6] = '{3, 1'b0, 16'hFFFF, 16'h0000, 16'h12BE};
      tbl[7] = '{0, 1'b0, 16'hFC02, 16'h0000, 16'hABCD};

      // reset values
      #12;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
      chk("rst_mem_din", 32'(mem_din), 0);
      do_reset();

      // requester 0 writes 0xABCD at 0x002, cycle by cycle
      t_wr[0] = 1'b1; t_addr[0] = 16'h0002; t_wdata[0] = 16'hABCD;
      drive_fields();
      req_v = 4'b0001;
      @(posedge clock); #1;
      chk("w_t1_grant", 32'(grant), 32'h1);
      chk("w_t1_busy", 32'(busy), 1);
      chk("w_t1_wr_en", 32'(mem_wr_en), 1);
      chk("w_t1_addr", 32'(mem_addr), 32'd2);
      chk("w_t1_din", 32'(mem_din), 32'hCD);
      chk("w_t1_ack", 32'(ack), 0);
      @(posedge clock); #1;
      chk("w_t2_wr_en", 32'(mem_wr_en), 1);
      chk("w_t2_addr", 32'(mem_addr), 32'd3);
      chk("w_t2_din", 32'(mem_din), 32'hAB);
      @(posedge clock); #1;
      chk("w_t3_ack", 32'(ack), 32'h1);
      chk("w_t3_wr_en", 32'(mem_wr_en), 0);
      req_v = '0;
      ref_mem[2] = 8'hCD;
      ref_mem[3] = 8'hAB;
      exp_pulses += 2;
      m_last = 0;
      @(posedge clock); #1;
      chk("w_idle_busy", 32'(busy), 0);
      chk("w_idle_grant", 32'(grant), 0);

      // single-requester vectors: reads, writes, address wrap and masking
      for (int v = 0; v < 8; v++) begin
         t_wr[tbl[v].idx]    = tbl[v].wr;
         t_addr[tbl[v].idx]  = tbl[v].addr;
         t_wdata[tbl[v].idx] = tbl[v].wdata;
         run_round(4'(1) << tbl[v].idx);
         chk($sformatf("tbl%0d_rdata", v), 32'(rdata), 32'(tbl[v].exp_rdata));
      end
      chk("wrap_byte0", 32'(mem[0]), 32'h12);
      chk("wrap_byte1022", 32'(mem[1022]), 32'hEF);
      chk("wrap_byte1023", 32'(mem[1023]), 32'hBE);

      // all four request together after reset, then requester 0 again
      do_reset();
      for (int i = 0; i < 4; i++) begin
         t_wr[i]    = 1'b1;
         t_addr[i]  = 16'h0200 + 16'(i * 16);
         t_wdata[i] = 16'h1100 * 16'(i + 1) + 16'(i);
      end
      run_round(4'b1111);
      t_wr[0]   = 1'b0;
      t_addr[0] = 16'h0210;
      run_round(4'b0001);
      chk("fair_reread", 32'(rdata), 32'h2201);

      // reset during HI of a write: only the low byte lands
      t_wr[0] = 1'b1; t_addr[0] = 16'h0100; t_wdata[0] = 16'h7766;
      drive_fields();
      req_v = 4'b0001;
      @(posedge clock); #1;
      @(posedge clock); #1;
      #2;
      nrst = 1'b0;
      #1;
      chk("arst_grant", 32'(grant), 0);
      chk("arst_ack", 32'(ack), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_rdata", 32'(rdata), 0);
      chk("arst_mem_addr", 32'(mem_addr), 0);
      chk("arst_mem_wr_en", 32'(mem_wr_en), 0);
      chk("arst_mem_din", 32'(mem_din), 0);
      req_v = '0;
      ref_mem[16'h0100] = 8'h66;
      exp_pulses += 1;
      @(posedge clock); #1;
      nrst   = 1'b1;
      m_last = 3;
      t_wr[0] = 1'b0; t_addr[0] = 16'h0100;
      t_wr[2] = 1'b0; t_addr[2] = 16'h0100;
      run_round(4'b0101);
      chk("arst_low_only", 32'(rdata), 32'h0066);

      // randomized rounds against the reference model
      for (int n = 0; n < 60; n++) begin
         logic [3:0] mask;
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            t_wr[i] = 1'($urandom_range(0, 1));
            r = 16'($urandom_range(0, 31)) ^ (16'($urandom_range(0, 63)) << 10);
            if ($urandom_range(0, 7) == 0) r = r | 16'h03FF;
            t_addr[i]  = r;
            t_wdata[i] = 16'($urandom);
         end
         run_round(mask);
      end

      chk("wr_pulse_count", 32'(wr_pulses), 32'(exp_pulses));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
